// File: rtl/lib_pipe_pkg.sv
// Shared types for the ready/valid retiming pipe.
package lib_pipe_pkg;

  // Occupancy state of a single skid slice.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_t;

endpackage

// File: rtl/lib_skid_slice.sv
// One fully registered ready/valid slice with a main and a skid register.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | nothing held; out_vld=0, in_rdy=1
// ONE   | main holds the output beat; out_vld=1, in_rdy=1
// TWO   | main holds the output beat, skid holds the next; in_rdy=0
//
// in_rdy is a flop loaded from the next state, so out_rdy_i never reaches
// in_rdy_o combinationally. The skid register catches the one beat that
// arrives in the cycle when downstream stalls while in_rdy is still high.
module lib_skid_slice
  import lib_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_rdy_i
);

  slice_state_t     state_q, state_d;
  logic             vld_q;
  logic             rdy_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic in_xfer;
  logic load_main;
  logic load_skid;
  logic main_from_skid;

  // Accept only while our registered ready is high; this also masks the
  // first cycle after reset, when ready is still low.
  assign in_xfer = in_vld_i & rdy_q;

  // State, valid and ready flops; valid and ready are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d != EMPTY);
      rdy_q   <= (state_d != TWO);
    end
  end

  // Next-state decode from the input and output handshakes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) state_d = ONE;
      end
      ONE: begin
        if (in_xfer && !out_rdy_i)      state_d = TWO;
        else if (!in_xfer && out_rdy_i) state_d = EMPTY;
      end
      TWO: begin
        if (out_rdy_i) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Datapath load enables for the main and skid registers.
  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        load_main = in_xfer;
      end
      ONE: begin
        load_main = in_xfer & out_rdy_i;
        load_skid = in_xfer & ~out_rdy_i;
      end
      TWO: begin
        load_main      = out_rdy_i;
        main_from_skid = 1'b1;
      end
      default: begin
        load_main = 1'b0;
      end
    endcase
  end

  // Data registers carry no reset; validity is tracked by the state flops.
  always_ff @(posedge clk) begin
    if (load_main) main_q <= main_from_skid ? skid_q : in_data_i;
    if (load_skid) skid_q <= in_data_i;
  end

  assign in_rdy_o   = rdy_q;
  assign out_vld_o  = vld_q;
  assign out_data_o = main_q;

endmodule

// File: rtl/lib_pipe_rdy.sv
// Ready/valid retiming pipe: DEPTH skid slices in series plus an occupancy
// counter. Both valid and ready are registered in every slice.
module lib_pipe_rdy #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_vld_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_rdy_o,
  output logic             m_vld_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_rdy_i,
  output logic [LVL_W-1:0] level_o
);

  if (DEPTH < 1) begin : g_depth_chk
    $fatal(1, "lib_pipe_rdy: DEPTH must be at least 1");
  end

  // Link k sits between slice k-1 and slice k; link 0 is the s-side port,
  // link DEPTH the m-side port.
  wire [DEPTH:0]   vld_w;
  wire [DEPTH:0]   rdy_w;
  wire [WIDTH-1:0] data_w [DEPTH+1];

  assign vld_w[0]     = s_vld_i;
  assign data_w[0]    = s_data_i;
  assign rdy_w[DEPTH] = m_rdy_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    lib_skid_slice #(
      .WIDTH (WIDTH)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .in_vld_i   (vld_w[k]),
      .in_data_i  (data_w[k]),
      .in_rdy_o   (rdy_w[k]),
      .out_vld_o  (vld_w[k+1]),
      .out_data_o (data_w[k+1]),
      .out_rdy_i  (rdy_w[k+1])
    );
  end

  assign s_rdy_o  = rdy_w[0];
  assign m_vld_o  = vld_w[DEPTH];
  assign m_data_o = data_w[DEPTH];

  logic             s_xfer;
  logic             m_xfer;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  assign s_xfer = s_vld_i & s_rdy_o;
  assign m_xfer = m_vld_o & m_rdy_i;

  // Occupancy moves by one per unmatched transfer at either end.
  always_comb begin
    lvl_d = lvl_q;
    if (s_xfer && !m_xfer)      lvl_d = lvl_q + LVL_W'(1);
    else if (!s_xfer && m_xfer) lvl_d = lvl_q - LVL_W'(1);
  end

  // Occupancy register; reset discards everything held.
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_d;
  end

  assign level_o = lvl_q;

endmodule

// File: tb/tb_lib_pipe_rdy.sv
module tb_lib_pipe_rdy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DEPTH=2, index 1: DEPTH=3, index 2: DEPTH=1.
  logic [2:0] rst;
  logic [2:0] s_vld;
  logic [2:0] m_rdy;
  logic [7:0] s_data [3];
  wire  [2:0] s_rdy_w;
  wire  [2:0] m_vld_w;
  wire  [7:0] m_data0, m_data1, m_data2;
  wire  [2:0] lvl0, lvl1;
  wire  [1:0] lvl2;

  lib_pipe_rdy #(.WIDTH(8), .DEPTH(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .s_vld_i(s_vld[0]), .s_data_i(s_data[0]), .s_rdy_o(s_rdy_w[0]),
    .m_vld_o(m_vld_w[0]), .m_data_o(m_data0), .m_rdy_i(m_rdy[0]), .level_o(lvl0));

  lib_pipe_rdy #(.WIDTH(8), .DEPTH(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .s_vld_i(s_vld[1]), .s_data_i(s_data[1]), .s_rdy_o(s_rdy_w[1]),
    .m_vld_o(m_vld_w[1]), .m_data_o(m_data1), .m_rdy_i(m_rdy[1]), .level_o(lvl1));

  lib_pipe_rdy #(.WIDTH(8), .DEPTH(1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .s_vld_i(s_vld[2]), .s_data_i(s_data[2]), .s_rdy_o(s_rdy_w[2]),
    .m_vld_o(m_vld_w[2]), .m_data_o(m_data2), .m_rdy_i(m_rdy[2]), .level_o(lvl2));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mdl_lvl = 0;
  int n_out = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out = -1;
  logic last_sx, last_mx;
  logic [7:0] sb_q [$];

  typedef struct packed {
    logic [1:0] idx;
    logic       r;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_srdy;
    logic       e_mvld;
    logic [7:0] e_md;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [7:0] get_mdata(input int i);
    case (i)
      0:       return m_data0;
      1:       return m_data1;
      default: return m_data2;
    endcase
  endfunction

  function automatic logic [31:0] get_lvl(input int i);
    case (i)
      0:       return {29'd0, lvl0};
      1:       return {29'd0, lvl1};
      default: return {30'd0, lvl2};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs after a falling edge, score the handshakes that
  // will occur at the next rising edge, then compare level at the next fall.
  task automatic step(input int i, input logic r, input logic sv, input logic [7:0] sd,
                      input logic mr);
    logic sx, mx;
    logic [7:0] exp;
    rst[i]    = r;
    s_vld[i]  = sv;
    s_data[i] = sd;
    m_rdy[i]  = mr;
    #1;
    sx = sv & s_rdy_w[i] & ~r;
    mx = m_vld_w[i] & mr & ~r;
    last_sx = sx;
    last_mx = mx;
    if (r) begin
      sb_q.delete();
      mdl_lvl = 0;
    end else begin
      if (mx) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", {24'd0, get_mdata(i)}, 32'hFFFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          check("sb_data", {24'd0, get_mdata(i)}, {24'd0, exp});
        end
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        mdl_lvl--;
      end
      if (sx) begin
        sb_q.push_back(sd);
        if (first_acc < 0) first_acc = cyc;
        mdl_lvl++;
      end
    end
    @(negedge clk);
    cyc++;
    check("level_vs_model", get_lvl(i), mdl_lvl);
  endtask

  task automatic add(input int idx, input logic r, input logic sv, input logic [7:0] sd,
                     input logic mr, input logic e_srdy, input logic e_mvld,
                     input logic [7:0] e_md, input int e_lvl);
    vec_t v;
    v.idx    = idx[1:0];
    v.r      = r;
    v.sv     = sv;
    v.sd     = sd;
    v.mr     = mr;
    v.e_srdy = e_srdy;
    v.e_mvld = e_mvld;
    v.e_md   = e_md;
    v.e_lvl  = e_lvl[2:0];
    tbl.push_back(v);
  endtask

  initial begin
    int budget;
    int sent;
    logic [7:0] nd;
    logic sv;
    vec_t v;

    rst   = 3'b111;
    s_vld = 3'b000;
    m_rdy = 3'b000;
    for (int i = 0; i < 3; i++) s_data[i] = 8'h00;

    // DEPTH=2: reset/idle, then full stall and resume.
    //   idx r sv data  mr | srdy mvld mdata lvl
    add(0, 1, 0, 8'h00, 0,   0, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 0,   0, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 0,   0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0);
    add(0, 0, 1, 8'h01, 0,   1, 0, 8'h00, 1);
    add(0, 0, 1, 8'h02, 0,   1, 1, 8'h01, 2);
    add(0, 0, 1, 8'h03, 0,   1, 1, 8'h01, 3);
    add(0, 0, 1, 8'h04, 0,   0, 1, 8'h01, 4);
    add(0, 0, 1, 8'h05, 0,   0, 1, 8'h01, 4);
    add(0, 0, 1, 8'h05, 1,   0, 1, 8'h02, 3);
    add(0, 0, 0, 8'h00, 1,   1, 1, 8'h03, 2);
    add(0, 0, 0, 8'h00, 1,   1, 1, 8'h04, 1);
    add(0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0);
    // DEPTH=1: capacity 2, ready recovers one cycle after m_rdy rises.
    add(2, 1, 0, 8'h00, 0,   0, 0, 8'h00, 0);
    add(2, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0);
    add(2, 0, 1, 8'h01, 0,   1, 1, 8'h01, 1);
    add(2, 0, 1, 8'h02, 0,   0, 1, 8'h01, 2);
    add(2, 0, 1, 8'h03, 0,   0, 1, 8'h01, 2);
    add(2, 0, 1, 8'h03, 1,   1, 1, 8'h02, 1);
    add(2, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0);

    @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      step(int'(v.idx), v.r, v.sv, v.sd, v.mr);
      check($sformatf("tbl%0d_s_rdy", k), {31'd0, s_rdy_w[v.idx]}, {31'd0, v.e_srdy});
      check($sformatf("tbl%0d_m_vld", k), {31'd0, m_vld_w[v.idx]}, {31'd0, v.e_mvld});
      if (v.e_mvld)
        check($sformatf("tbl%0d_m_data", k), {24'd0, get_mdata(int'(v.idx))}, {24'd0, v.e_md});
      check($sformatf("tbl%0d_level", k), get_lvl(int'(v.idx)), {29'd0, v.e_lvl});
    end
    check("tbl_sb_empty", sb_q.size(), 0);

    // DEPTH=2 streaming: 16 back-to-back beats, latency 2, level steady at 2.
    n_out = 0; first_acc = -1; first_out = -1; last_out = -1; sent = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 8'(k + 1), 1);
      if (last_sx) sent++;
      if (k >= 1) check("stream_level", get_lvl(0), 2);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 8'h00, 1);
    check("stream_accepted", sent, 16);
    check("stream_delivered", n_out, 16);
    check("stream_latency", first_out - first_acc, 2);
    check("stream_consecutive", last_out - first_out, 15);
    check("stream_sb_empty", sb_q.size(), 0);

    // DEPTH=2 mid-stream reset with three beats held.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'(8'h51 + k), 0);
    check("mrst_level_before", get_lvl(0), 3);
    step(0, 1, 0, 8'h00, 0);
    check("mrst_m_vld", {31'd0, m_vld_w[0]}, 0);
    check("mrst_level", get_lvl(0), 0);
    check("mrst_s_rdy", {31'd0, s_rdy_w[0]}, 0);
    step(0, 0, 0, 8'h00, 1);
    check("mrst_s_rdy_release", {31'd0, s_rdy_w[0]}, 1);
    n_out = 0;
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'(8'hA0 + k), 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 8'h00, 1);
    check("mrst_delivered", n_out, 4);
    check("mrst_sb_empty", sb_q.size(), 0);

    // DEPTH=3 random backpressure, 10000 beats.
    step(1, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    n_out = 0; sent = 0; nd = 8'h00; budget = 0;
    while (n_out < 10000 && budget < 60000) begin
      sv = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1, 0, sv, nd, 1'($urandom_range(0, 1)));
      if (last_sx) begin
        nd++;
        sent++;
      end
      check("rand_level_max", {31'd0, get_lvl(1) <= 6}, 1);
      budget++;
    end
    check("rand_delivered", n_out, 10000);
    check("rand_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
